// File: rtl/thor2022_tlb_walker_if.sv
// Memory read bus between the TLB walker (master) and the page-table memory (slave).
interface thor2022_tlb_walker_if;
  logic        mreq_o;
  logic [31:0] madr_o;
  logic        mack_i;
  logic        merr_i;
  logic [63:0] mdat_i;

  modport master (output mreq_o, output madr_o, input mack_i, input merr_i, input mdat_i);
  modport slave  (input mreq_o, input madr_o, output mack_i, output merr_i, output mdat_i);
endinterface

// File: rtl/thor2022_tlb_walker.sv
// Single-level page-table walker: fetches one PTE on a TLB miss, writes it into the
// TLB tagged with the captured ASID, and reports sticky faults for bad PTEs, bus errors and timeouts.
module thor2022_tlb_walker #(
  parameter logic [7:0] TMO    = 8'd255,
  parameter logic [2:0] SETTLE = 3'd4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           walk_en_i,
  input  logic                           miss_i,
  input  logic [31:0]                    miss_adr_i,
  input  logic [7:0]                     asid_i,
  input  logic [31:0]                    ptbr_i,
  thor2022_tlb_walker_if.master          mem,
  output logic                           wrtlb_o,
  output logic [15:0]                    tlbadr_o,
  output logic [63:0]                    tlbdat_o,
  output logic                           busy_o,
  output logic                           fault_o,
  output logic [1:0]                     fault_code_o,
  output logic [31:0]                    fault_adr_o,
  input  logic                           fault_clr_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_CHK   = 3'd2,
    S_WR    = 3'd3,
    S_HOLD  = 3'd4,
    S_FAULT = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] vadr_q, vadr_d;
  logic [7:0]  asid_q, asid_d;
  logic [63:0] pte_q, pte_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [2:0]  hold_q, hold_d;
  logic        mreq_q, mreq_d;
  logic [31:0] madr_q, madr_d;
  logic        wrtlb_q, wrtlb_d;
  logic [15:0] tlbadr_q, tlbadr_d;
  logic [63:0] tlbdat_q, tlbdat_d;
  logic        busy_q, busy_d;
  logic        fault_q, fault_d;
  logic [1:0]  fcode_q, fcode_d;
  logic [31:0] fadr_q, fadr_d;
  logic        fault_set_s;
  logic [1:0]  fault_new_code_s;

  // Next-state and next-output computation for the walk sequence.
  always_comb begin
    state_d          = state_q;
    vadr_d           = vadr_q;
    asid_d           = asid_q;
    pte_d            = pte_q;
    tmo_d            = tmo_q;
    hold_d           = hold_q;
    mreq_d           = mreq_q;
    madr_d           = madr_q;
    wrtlb_d          = 1'b0;
    tlbadr_d         = tlbadr_q;
    tlbdat_d         = tlbdat_q;
    fault_d          = fault_q;
    fcode_d          = fcode_q;
    fadr_d           = fadr_q;
    fault_set_s      = 1'b0;
    fault_new_code_s = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (miss_i && walk_en_i && !fault_q) begin
          state_d = S_REQ;
          vadr_d  = miss_adr_i;
          asid_d  = asid_i;
          madr_d  = ptbr_i + {9'd0, miss_adr_i[31:12], 3'b000};
          mreq_d  = 1'b1;
          tmo_d   = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        // A bus error outranks a simultaneous acknowledge.
        if (mem.merr_i) begin
          mreq_d           = 1'b0;
          state_d          = S_FAULT;
          fault_set_s      = 1'b1;
          fault_new_code_s = 2'b10;
        end else if (mem.mack_i) begin
          mreq_d  = 1'b0;
          pte_d   = mem.mdat_i;
          state_d = S_CHK;
        end else if (tmo_q == TMO - 8'd1) begin
          mreq_d           = 1'b0;
          state_d          = S_FAULT;
          fault_set_s      = 1'b1;
          fault_new_code_s = 2'b11;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_CHK: begin
        if (!pte_q[0]) begin
          state_d          = S_FAULT;
          fault_set_s      = 1'b1;
          fault_new_code_s = 2'b01;
        end else begin
          state_d  = S_WR;
          wrtlb_d  = 1'b1;
          tlbadr_d = {2'b10, 4'h0, vadr_q[21:12]};
          tlbdat_d = {asid_q, 56'd0} | (pte_q & {8'h00, {56{1'b1}}});
        end
      end
      S_WR: begin
        state_d = S_HOLD;
        hold_d  = SETTLE;
      end
      S_HOLD: begin
        if (hold_q <= 3'd1) begin
          state_d = S_IDLE;
          hold_d  = 3'd0;
        end else begin
          hold_d = hold_q - 3'd1;
        end
      end
      S_FAULT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        mreq_d  = 1'b0;
      end
    endcase

    // A fault raised in the same cycle as a clear must survive the clear.
    if (fault_clr_i) begin
      fault_d = 1'b0;
      fcode_d = 2'b00;
    end else begin
      fault_d = fault_d;
    end
    if (fault_set_s) begin
      fault_d = 1'b1;
      fcode_d = fault_new_code_s;
      fadr_d  = vadr_q;
    end else begin
      fadr_d = fadr_d;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and registered-output update with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      vadr_q   <= 32'd0;
      asid_q   <= 8'd0;
      pte_q    <= 64'd0;
      tmo_q    <= 8'd0;
      hold_q   <= 3'd0;
      mreq_q   <= 1'b0;
      madr_q   <= 32'd0;
      wrtlb_q  <= 1'b0;
      tlbadr_q <= 16'd0;
      tlbdat_q <= 64'd0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
      fcode_q  <= 2'b00;
      fadr_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      vadr_q   <= vadr_d;
      asid_q   <= asid_d;
      pte_q    <= pte_d;
      tmo_q    <= tmo_d;
      hold_q   <= hold_d;
      mreq_q   <= mreq_d;
      madr_q   <= madr_d;
      wrtlb_q  <= wrtlb_d;
      tlbadr_q <= tlbadr_d;
      tlbdat_q <= tlbdat_d;
      busy_q   <= busy_d;
      fault_q  <= fault_d;
      fcode_q  <= fcode_d;
      fadr_q   <= fadr_d;
    end
  end

  assign mem.mreq_o   = mreq_q;
  assign mem.madr_o   = madr_q;
  assign wrtlb_o      = wrtlb_q;
  assign tlbadr_o     = tlbadr_q;
  assign tlbdat_o     = tlbdat_q;
  assign busy_o       = busy_q;
  assign fault_o      = fault_q;
  assign fault_code_o = fcode_q;
  assign fault_adr_o  = fadr_q;

endmodule

// File: doc/thor2022_tlb_walker.md
THOR2022_TLB_WALKER -- requirements
Module: Thor2022_tlb_walker

Interface
REQ-001 Parameter TMO, default 8'd255: bus-ack timeout in cycles.
REQ-002 Parameter SETTLE, default 3'd4: cycles of holdoff after a TLB write before a new miss is accepted.
REQ-003 Port clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 Port walk_en_i  input  1  enables acceptance of new misses.
REQ-006 Port miss_i  input  1  TLB miss indication (level).
REQ-007 Port miss_adr_i  input  32  virtual address that missed.
REQ-008 Port asid_i  input  8  current address-space ID.
REQ-009 Port ptbr_i  input  32  page-table base address.
REQ-010 Port mreq_o  output  1  memory read request.
REQ-011 Port madr_o  output  32  PTE address.
REQ-012 Port mack_i  input  1  memory acknowledge, data valid.
REQ-013 Port merr_i  input  1  memory bus error.
REQ-014 Port mdat_i  input  64  PTE read data.
REQ-015 Port wrtlb_o  output  1  TLB write strobe.
REQ-016 Port tlbadr_o  output  16  TLB write address.
REQ-017 Port tlbdat_o  output  64  TLB entry to write.
REQ-018 Port busy_o  output  1  walk in progress, including holdoff.
REQ-019 Port fault_o  output  1  walk fault, sticky.
REQ-020 Port fault_code_o  output  2  01 invalid PTE, 10 bus error, 11 timeout.
REQ-021 Port fault_adr_o  output  32  miss address of the faulting walk.
REQ-022 Port fault_clr_i  input  1  clears fault_o.

Function
REQ-023 States: IDLE, REQ, CHK, WR, HOLD, FAULT.
REQ-024 IDLE: transition to REQ when miss_i & walk_en_i & ~fault_o; capture miss_adr_i and asid_i into internal registers in the same cycle.
REQ-025 madr_o shall equal ptbr_i + {captured vaddr[31:12], 3'b000}, computed modulo 2^32 (wrap, no carry out); registered at REQ entry and held stable while mreq_o=1.
REQ-026 REQ: mreq_o=1 until mack_i or merr_i is sampled; the 8-bit timeout counter clears on REQ entry and increments each REQ cycle.
REQ-027 mack_i: latch mdat_i, drop mreq_o, go to CHK.
REQ-028 merr_i (including merr_i together with mack_i): merr wins; fault code 10; go to FAULT.
REQ-029 Counter reaches TMO with no ack or error: fault code 11; go to FAULT.
REQ-030 CHK: PTE bit0=0 means fault code 01 and transition to FAULT; otherwise go to WR.
REQ-031 WR: wrtlb_o=1 for exactly one cycle; tlbadr_o={2'b10,4'h0,vaddr[21:12]} (random-way write); tlbdat_o = latched PTE with bits[63:56] replaced by captured asid.
REQ-032 HOLD: SETTLE cycles (count down from SETTLE to zero), then IDLE; miss_i is ignored throughout.
REQ-033 FAULT: set fault_o, fault_code_o, and fault_adr_o = captured vaddr; go to IDLE next cycle; fault_o, fault_code_o and fault_adr_o hold until fault_clr_i.
REQ-034 fault_clr_i clears fault_o and fault_code_o; when fault_clr_i coincides with a new fault, the new fault wins.
REQ-035 busy_o=1 in every state except IDLE.
REQ-036 walk_en_i falling mid-walk does not abort; the walk completes or faults normally.
REQ-037 miss_i changes while not in IDLE are ignored; no queuing.
REQ-038 Worst-case latency, miss to wrtlb_o: 1 (IDLE) + ack wait + 1 (CHK) + 1 (WR); minimum 4 cycles with a same-cycle ack.

Reset
REQ-039 rst_ni=0 asynchronously forces IDLE and clears all counters and outputs: mreq_o, wrtlb_o, busy_o, fault_o = 0; madr_o, tlbadr_o, tlbdat_o, fault_adr_o = 0; fault_code_o = 00.
REQ-040 Reset asserted mid-walk abandons the walk; no wrtlb_o pulse follows reset release.

Verification
REQ-041 ptbr=0x00100000, miss_adr=0x12345678, asid=0x05, ack after 3 cycles with PTE 0x00000000_00ABC001 -> madr=0x00191A28, one wrtlb pulse, tlbadr=0x8345, tlbdat=0x05000000_00ABC001.
REQ-042 ptbr=0xFFFFFFF8, miss_adr=0x00002000 -> madr=0x00000008 (wrap).
REQ-043 PTE bit0=0 -> fault_o=1, code 01, fault_adr=miss address, no wrtlb; further misses ignored until fault_clr_i.
REQ-044 No ack for 255 cycles -> code 11, mreq_o drops; separate run with mack_i and merr_i in same cycle -> code 10.
REQ-045 miss_i held high across a completed walk -> no new REQ before the 4 HOLD cycles elapse.
REQ-046 rst_ni low during REQ -> mreq_o and busy_o drop immediately, no clock edge required.
